// File: rtl/cache_bus_pkg.sv
// Shared definitions for the core/cache request bus: tag layout, tag field
// encodings and the responder state machine states.
package cache_bus_pkg;

  localparam int TAG_W        = 13;
  localparam int TAG_RW_BIT   = 12;
  localparam int TAG_TYPE_LSB = 8;
  localparam int TAG_TYPE_W   = 4;

  localparam logic                  RW_READ  = 1'b1;
  localparam logic                  RW_WRITE = 1'b0;
  localparam logic [TAG_TYPE_W-1:0] MEMORY   = 4'h1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL_REQ,
    FILL_WAIT,
    RESP
  } stateT;

  // A tag this cache can serve: a READ of the MEMORY type.
  function automatic logic tagIsMemRead(input logic [TAG_W-1:0] tag);
    return (tag[TAG_RW_BIT] == RW_READ) &&
           (tag[TAG_TYPE_LSB +: TAG_TYPE_W] == MEMORY);
  endfunction

endpackage

// File: rtl/dcache_core_responder_if.sv
// Core/cache request bus: request handshake from the Memory stage and the
// response handshake back to it.
interface dcache_core_responder_if;
  import cache_bus_pkg::*;

  logic             reqcyc;
  logic [63:0]      req;
  logic [TAG_W-1:0] reqtag;
  logic             reqack;
  logic             respcyc;
  logic [63:0]      resp;
  logic [TAG_W-1:0] resptag;
  logic             respack;

  // Core side issues requests and consumes responses.
  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  // Cache side accepts requests and produces responses.
  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );

endinterface

// File: rtl/dcache_line_array.sv
// Direct-mapped line storage: valid bits in flops, tag/data in arrays with a
// combinational read port and one synchronous write port.
module dcache_line_array #(
  parameter int LINES  = 16,
  parameter int IDX_W  = $clog2(LINES),
  parameter int LTAG_W = 61 - IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rdIndex,
  output logic              rdValid,
  output logic [LTAG_W-1:0] rdTag,
  output logic [63:0]       rdData,
  input  logic              wrEn,
  input  logic [IDX_W-1:0]  wrIndex,
  input  logic [LTAG_W-1:0] wrTag,
  input  logic [63:0]       wrData,
  input  logic              flushAll
);

  logic [LINES-1:0]  validReg;
  logic [LTAG_W-1:0] tagMem  [LINES];
  logic [63:0]       dataMem [LINES];

  // Per-line valid bit; a flush on the same edge as a write wins.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : gValid
      always_ff @(posedge clk) begin
        if (reset || flushAll)
          validReg[gi] <= 1'b0;
        else if (wrEn && (wrIndex == IDX_W'(gi)))
          validReg[gi] <= 1'b1;
      end
    end
  endgenerate

  // Tag and data payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      tagMem[wrIndex]  <= wrTag;
      dataMem[wrIndex] <= wrData;
    end
  end

  assign rdValid = validReg[rdIndex];
  assign rdTag   = tagMem[rdIndex];
  assign rdData  = dataMem[rdIndex];

endmodule

// File: rtl/dcache_core_responder.sv
// Cache-side responder: serves 64-bit reads from a direct-mapped read-only
// cache, filling from a downstream memory port on a miss.
module dcache_core_responder
  import cache_bus_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  dcache_core_responder_if.slave  bus,
  output logic                    mem_reqcyc,
  output logic [63:0]             mem_req,
  input  logic                    mem_reqack,
  input  logic                    mem_respcyc,
  input  logic [63:0]             mem_resp,
  output logic                    mem_respack,
  input  logic                    flush,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
  output logic                    protocol_err
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int LTAG_W = 61 - IDX_W;

  stateT       state;
  logic [63:3] reqAddr;
  logic        flushPending;

  logic              rdValid;
  logic [LTAG_W-1:0] rdTag;
  logic [63:0]       rdData;
  logic              fillNow;
  logic              respDone;
  logic              flushAll;
  logic              isHit;
  logic              unusedReqLsbs;

  // Reads are 8-byte aligned; the low address bits carry no information.
  assign unusedReqLsbs = &{1'b0, bus.req[2:0]};

  assign isHit    = rdValid && (rdTag == reqAddr[63:3+IDX_W]);
  assign fillNow  = mem_respcyc &&
                    ((state == FILL_WAIT) || (state == FILL_REQ && mem_reqack));
  assign respDone = (state == RESP) && bus.respcyc && bus.respack;
  // Flushes seen mid-transaction are deferred until the return to IDLE.
  assign flushAll = ((state == IDLE) && flush) ||
                    (respDone && (flushPending || flush));

  dcache_line_array #(.LINES(LINES)) uLines (
    .clk      (clk),
    .reset    (reset),
    .rdIndex  (reqAddr[3 +: IDX_W]),
    .rdValid  (rdValid),
    .rdTag    (rdTag),
    .rdData   (rdData),
    .wrEn     (fillNow),
    .wrIndex  (reqAddr[3 +: IDX_W]),
    .wrTag    (reqAddr[63:3+IDX_W]),
    .wrData   (mem_resp),
    .flushAll (flushAll)
  );

  // Request/lookup/fill/response sequencing with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      reqAddr      <= '0;
      flushPending <= 1'b0;
      bus.reqack   <= 1'b0;
      bus.respcyc  <= 1'b0;
      bus.resp     <= '0;
      bus.resptag  <= '0;
      mem_reqcyc   <= 1'b0;
      mem_req      <= '0;
      mem_respack  <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
      protocol_err <= 1'b0;
    end else begin
      bus.reqack  <= 1'b0;
      mem_respack <= 1'b0;
      if (state != IDLE && flush)
        flushPending <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.reqcyc) begin
            reqAddr     <= bus.req[63:3];
            bus.resptag <= bus.reqtag;   // also serves as the latched tag
            bus.reqack  <= 1'b1;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!tagIsMemRead(bus.resptag)) begin
            protocol_err <= 1'b1;
            bus.resp     <= '0;
            bus.respcyc  <= 1'b1;
            state        <= RESP;
          end else if (isHit) begin
            if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            bus.resp    <= rdData;
            bus.respcyc <= 1'b1;
            state       <= RESP;
          end else begin
            if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            mem_reqcyc <= 1'b1;
            mem_req    <= {reqAddr, 3'b000};
            state      <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (mem_reqack) begin
            mem_reqcyc <= 1'b0;
            if (mem_respcyc) begin
              bus.resp    <= mem_resp;
              mem_respack <= 1'b1;
              bus.respcyc <= 1'b1;
              state       <= RESP;
            end else begin
              state <= FILL_WAIT;
            end
          end
        end
        FILL_WAIT: begin
          if (mem_respcyc) begin
            bus.resp    <= mem_resp;
            mem_respack <= 1'b1;
            bus.respcyc <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (respDone) begin
            bus.respcyc  <= 1'b0;
            flushPending <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_core_responder.sv
// Self-checking bench for dcache_core_responder: directed test-plan steps
// followed by randomized reads against a line-level cache model.
module tb_dcache_core_responder;
  import cache_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_reqcyc;
  logic [63:0] mem_req;
  logic        mem_reqack;
  logic        mem_respcyc;
  logic [63:0] mem_resp;
  logic        mem_respack;
  logic        flush;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  // Reference model: what each of the 16 lines holds, plus expected counters.
  bit          mValid [16];
  logic [56:0] mTag   [16];
  logic [63:0] mData  [16];
  int          mHits;
  int          mMisses;
  bit          mPerr;

  dcache_core_responder_if bus ();

  dcache_core_responder #(.LINES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .mem_reqcyc   (mem_reqcyc),
    .mem_req      (mem_req),
    .mem_reqack   (mem_reqack),
    .mem_respcyc  (mem_respcyc),
    .mem_resp     (mem_resp),
    .mem_respack  (mem_respack),
    .flush        (flush),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string name);
    check({name, "_reqack"},  bus.reqack, 0);
    check({name, "_respcyc"}, bus.respcyc, 0);
    check({name, "_resp"},    bus.resp, 0);
    check({name, "_resptag"}, bus.resptag, 0);
    check({name, "_memreq"},  {mem_reqcyc, mem_respack}, 0);
    check({name, "_memaddr"}, mem_req, 0);
    check({name, "_hits"},    hit_count, 0);
    check({name, "_misses"},  miss_count, 0);
    check({name, "_perr"},    protocol_err, 0);
  endtask

  // One complete read transaction, starting and ending just after a negedge.
  task automatic readTxn(input logic [63:0] addr, input logic [12:0] tag,
                         input logic [63:0] fill, input int ackDly, input int dataDly,
                         input bit sameCyc, input int hold, input bit flushInWait,
                         input bit flushAtReq);
    int          idx;
    logic [56:0] t;
    bit          good;
    bit          hit;
    bit          pendFlush;
    logic [63:0] expResp;
    idx       = int'(addr[6:3]);
    t         = addr[63:7];
    good      = (tag[12] == 1'b1) && (tag[11:8] == 4'h1);
    pendFlush = 1'b0;
    if (flushAtReq) modelClear();
    hit = good && mValid[idx] && (mTag[idx] == t);

    bus.reqcyc = 1'b1; bus.req = addr; bus.reqtag = tag; flush = flushAtReq;
    @(negedge clk);
    flush = 1'b0; bus.reqcyc = 1'b0;
    check("reqack", bus.reqack, 1);
    @(negedge clk);
    if (!good) begin
      mPerr = 1'b1; expResp = '0;
      check("bad_respcyc", bus.respcyc, 1);
      check("bad_resp", bus.resp, 0);
      check("bad_memreq", mem_reqcyc, 0);
    end else if (hit) begin
      mHits++; expResp = mData[idx];
      check("hit_respcyc", bus.respcyc, 1);
      check("hit_resp", bus.resp, expResp);
      check("hit_memreq", mem_reqcyc, 0);
    end else begin
      mMisses++; expResp = fill;
      check("miss_respcyc", bus.respcyc, 0);
      check("miss_memreq", mem_reqcyc, 1);
      check("miss_memaddr", mem_req, addr & ~64'h7);
      for (int i = 0; i < ackDly; i++) begin
        @(negedge clk);
        check("fillreq_hold", mem_reqcyc, 1);
        check("fillreq_addr", mem_req, addr & ~64'h7);
      end
      mem_reqack = 1'b1;
      if (sameCyc) begin mem_respcyc = 1'b1; mem_resp = fill; end
      @(negedge clk);
      mem_reqack = 1'b0;
      check("fillreq_drop", mem_reqcyc, 0);
      if (sameCyc) begin
        mem_respcyc = 1'b0;
      end else begin
        for (int i = 0; i < dataDly; i++) begin
          if (flushInWait && i == 0) flush = 1'b1;
          @(negedge clk);
          flush = 1'b0;
          check("wait_respcyc", bus.respcyc, 0);
          check("wait_respack", mem_respack, 0);
        end
        mem_respcyc = 1'b1; mem_resp = fill;
        if (flushInWait && dataDly == 0) flush = 1'b1;
        @(negedge clk);
        mem_respcyc = 1'b0; flush = 1'b0;
      end
      check("fill_respcyc", bus.respcyc, 1);
      check("fill_resp", bus.resp, fill);
      check("fill_memrespack", mem_respack, 1);
      mValid[idx] = 1'b1; mTag[idx] = t; mData[idx] = fill;
      pendFlush = flushInWait && !sameCyc;
    end
    check("resptag", bus.resptag, tag);
    check("hit_count", hit_count, mHits);
    check("miss_count", miss_count, mMisses);
    check("protocol_err", protocol_err, mPerr);
    for (int i = 0; i < hold; i++) begin
      bus.reqcyc = 1'b1; bus.req = {$urandom, $urandom};
      @(negedge clk);
      check("hold_respcyc", bus.respcyc, 1);
      check("hold_resp", bus.resp, expResp);
      check("hold_noack", bus.reqack, 0);
      check("hold_memrespack", mem_respack, 0);
    end
    bus.reqcyc = 1'b0; bus.respack = 1'b1;
    @(negedge clk);
    bus.respack = 1'b0;
    check("done_respcyc", bus.respcyc, 0);
    check("done_memrespack", mem_respack, 0);
    check("done_noack", bus.reqack, 0);
    if (pendFlush) modelClear();
    $display("txn addr=%h tag=%h hit=%0d good=%0d resp=%h", addr, tag, hit, good, expResp);
  endtask

  initial begin
    logic [63:0] a;
    logic [12:0] tg;
    reset = 1'b1; flush = 1'b0;
    bus.reqcyc = 1'b0; bus.req = '0; bus.reqtag = '0; bus.respack = 1'b0;
    mem_reqack = 1'b0; mem_respcyc = 1'b0; mem_resp = '0;
    modelClear(); mHits = 0; mMisses = 0; mPerr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkIdleOutputs("reset");

    // Cold miss, hit, conflict eviction, backpressure.
    readTxn(64'h1000, 13'h118B, 64'hDEAD_BEEF_0000_0001, 2, 3, 0, 0, 0, 0);
    readTxn(64'h1000, 13'h118B, 64'h0, 0, 0, 0, 0, 0, 0);
    readTxn(64'h1080, 13'h1101, 64'h1111_2222_3333_4444, 0, 1, 0, 0, 0, 0);
    readTxn(64'h1000, 13'h1102, 64'hDEAD_BEEF_0000_0001, 1, 0, 1, 0, 0, 0);
    check("conflict_misses", miss_count, 3);
    readTxn(64'h1004, 13'h1103, 64'h0, 0, 0, 0, 6, 0, 0);

    // Flush during FILL_WAIT still responds, then the line is gone.
    readTxn(64'h2000, 13'h1104, 64'hCAFE_F00D_0000_2000, 0, 2, 0, 0, 1, 0);
    readTxn(64'h2000, 13'h1105, 64'hCAFE_F00D_0000_2001, 0, 0, 0, 0, 0, 0);
    // Flush in IDLE together with a request: lookup misses.
    readTxn(64'h2000, 13'h1106, 64'hCAFE_F00D_0000_2002, 0, 0, 0, 0, 0, 1);

    // WRITE tag: answered with zero data and protocol_err set.
    readTxn(64'h1000, 13'h018B, 64'h0, 0, 0, 0, 2, 0, 0);

    // Randomized reads over a few conflicting tags.
    for (int n = 0; n < 60; n++) begin
      a = 64'h4000 + (64'($urandom_range(0, 2)) << 7) + (64'($urandom_range(0, 15)) << 3)
          + 64'($urandom_range(0, 7));
      tg = {1'b1, 4'h1, 8'($urandom)};
      if ($urandom_range(0, 9) == 0) tg[12:8] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 11) == 0) begin
        flush = 1'b1; @(negedge clk); flush = 1'b0; modelClear();
      end
      readTxn(a, tg, {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 5) == 0,
              $urandom_range(0, 9) == 0);
    end

    // Reset during FILL_REQ abandons the fill; a late fill response is ignored.
    bus.reqcyc = 1'b1; bus.req = 64'h9000; bus.reqtag = 13'h11AA;
    @(negedge clk);
    bus.reqcyc = 1'b0;
    @(negedge clk);
    check("pre_reset_memreq", mem_reqcyc, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkIdleOutputs("midfill_reset");
    modelClear(); mHits = 0; mMisses = 0; mPerr = 1'b0;
    mem_respcyc = 1'b1; mem_resp = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    mem_respcyc = 1'b0;
    check("late_respcyc", bus.respcyc, 0);
    check("late_memrespack", mem_respack, 0);
    readTxn(64'h1000, 13'h118B, 64'h0123_4567_89AB_CDEF, 0, 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
